// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode response receiver.
package sd_pkg;

   localparam logic [1:0] RESP_R1   = 2'd0;
   localparam logic [1:0] RESP_R1B  = 2'd1;
   localparam logic [1:0] RESP_R2   = 2'd2;
   localparam logic [1:0] RESP_R3R7 = 2'd3;

   localparam int unsigned BIT_CNT_W = 6;
   localparam int unsigned LEN_R1    = 8;
   localparam int unsigned LEN_R2    = 16;
   localparam int unsigned LEN_R3R7  = 40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_SHIFT,
      ST_BUSY_WAIT,
      ST_DONE
   } state_e;

   // Wire length in bits of a response type, start bit included.
   function automatic logic [BIT_CNT_W-1:0] resp_len(input logic [1:0] t);
      case (t)
         RESP_R2:   resp_len = BIT_CNT_W'(LEN_R2);
         RESP_R3R7: resp_len = BIT_CNT_W'(LEN_R3R7);
         default:   resp_len = BIT_CNT_W'(LEN_R1);
      endcase
   endfunction

endpackage

// File: rtl/sd_down_counter.sv
// Loadable down counter with a registered zero flag; stops at zero.
module sd_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         zero_q, zero_d;

   always_comb begin
      cnt_d  = cnt_q;
      zero_d = zero_q;
      if (load_i) begin
         cnt_d  = load_val_i;
         zero_d = (load_val_i == '0);
      end else if (dec_i && !zero_q) begin
         cnt_d  = cnt_q - W'(1);
         zero_d = (cnt_q == W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/sd_spi_resp_rx.sv
// SD SPI-mode response receiver: start-bit hunt, R1/R1b/R2/R3/R7 shift-in,
// R1b busy tracking, Ncr and busy timeouts, one resp_valid per transaction.
module sd_spi_resp_rx
   import sd_pkg::*;
#(
   parameter int unsigned RESP_W   = 40,
   parameter int unsigned NCR_MAX  = 64,
   parameter int unsigned BUSY_MAX = 65535,
   parameter int unsigned CNT_W    =
      $clog2(((NCR_MAX > BUSY_MAX) ? NCR_MAX : BUSY_MAX) + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_en_i,
   input  logic              miso_i,
   input  logic              start_i,
   input  logic [1:0]        resp_type_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              resp_valid_o,
   output logic [RESP_W-1:0] resp_data_o,
   output logic              resp_timeout_o,
   output logic              busy_timeout_o
);

   state_e              state_q, state_d;
   logic [1:0]          type_q, type_d;
   logic [RESP_W-1:0]   data_q, data_d;
   logic                rt_q, rt_d, bt_q, bt_d;
   logic                busy_q, busy_d, valid_q, valid_d;

   logic                 bit_load, bit_dec, bit_zero;
   logic [BIT_CNT_W-1:0] bit_val;
   logic                 win_load, win_dec, win_zero;
   logic [CNT_W-1:0]     win_val;

   // Counters are preloaded with (count - 1) so the zero flag marks the deciding sample.
   sd_down_counter #(.W(BIT_CNT_W)) u_bit_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (bit_load),
      .load_val_i (bit_val),
      .dec_i      (bit_dec),
      .zero_o     (bit_zero)
   );

   // Ncr and busy windows never overlap, so they share one counter.
   sd_down_counter #(.W(CNT_W)) u_win_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (win_load),
      .load_val_i (win_val),
      .dec_i      (win_dec),
      .zero_o     (win_zero)
   );

   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      data_d   = data_q;
      rt_d     = rt_q;
      bt_d     = bt_q;
      bit_load = 1'b0;
      bit_val  = '0;
      bit_dec  = 1'b0;
      win_load = 1'b0;
      win_val  = '0;
      win_dec  = 1'b0;

      if (abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  type_d   = resp_type_i;
                  data_d   = '0;
                  rt_d     = 1'b0;
                  bt_d     = 1'b0;
                  bit_load = 1'b1;
                  bit_val  = resp_len(resp_type_i) - BIT_CNT_W'(2);
                  win_load = 1'b1;
                  win_val  = CNT_W'(NCR_MAX - 1);
                  state_d  = ST_WAIT_START;
               end
            end
            ST_WAIT_START: begin
               if (sample_en_i) begin
                  if (!miso_i) begin
                     data_d  = {data_q[RESP_W-2:0], 1'b0};
                     state_d = ST_SHIFT;
                  end else if (win_zero) begin
                     data_d  = '1;
                     rt_d    = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     win_dec = 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (sample_en_i) begin
                  data_d = {data_q[RESP_W-2:0], miso_i};
                  if (!bit_zero) begin
                     bit_dec = 1'b1;
                  end else if (type_q == RESP_R1B) begin
                     win_load = 1'b1;
                     win_val  = CNT_W'(BUSY_MAX - 1);
                     state_d  = ST_BUSY_WAIT;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_BUSY_WAIT: begin
               if (sample_en_i) begin
                  if (miso_i) begin
                     state_d = ST_DONE;
                  end else if (win_zero) begin
                     bt_d    = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     win_dec = 1'b1;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         type_q  <= RESP_R1;
         data_q  <= '0;
         rt_q    <= 1'b0;
         bt_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         data_q  <= data_d;
         rt_q    <= rt_d;
         bt_q    <= bt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o         = busy_q;
   assign resp_valid_o   = valid_q;
   assign resp_data_o    = data_q;
   assign resp_timeout_o = rt_q;
   assign busy_timeout_o = bt_q;

endmodule

// File: tb/tb_sd_spi_resp_rx.sv
// Directed bench for sd_spi_resp_rx: vector table plus hand-written corner sequences.
module tb_sd_spi_resp_rx;

   logic        clk, reset, sample_en, miso, start, abort;
   logic [1:0]  resp_type;
   logic        busy0, rv0, rt0, bt0, busy1, rv1, rt1, bt1;
   logic [39:0] data0, data1;
   int          checks = 0, errors = 0;
   int          vcnt0 = 0, vcnt1 = 0;

   sd_spi_resp_rx dut0 (
      .clk(clk), .reset(reset), .sample_en_i(sample_en), .miso_i(miso),
      .start_i(start), .resp_type_i(resp_type), .abort_i(abort),
      .busy_o(busy0), .resp_valid_o(rv0), .resp_data_o(data0),
      .resp_timeout_o(rt0), .busy_timeout_o(bt0));

   sd_spi_resp_rx #(.BUSY_MAX(50)) dut1 (
      .clk(clk), .reset(reset), .sample_en_i(sample_en), .miso_i(miso),
      .start_i(start), .resp_type_i(resp_type), .abort_i(abort),
      .busy_o(busy1), .resp_valid_o(rv1), .resp_data_o(data1),
      .resp_timeout_o(rt1), .busy_timeout_o(bt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count resp_valid pulses shortly after each active edge.
   always @(posedge clk) begin
      #1;
      if (rv0 === 1'b1) vcnt0 = vcnt0 + 1;
      if (rv1 === 1'b1) vcnt1 = vcnt1 + 1;
   end

   typedef struct {
      logic [1:0]  rtype;
      int          nbits;
      logic [39:0] stream;
      int          pre_ones;
      bit          gaps;
      logic [39:0] exp_data;
      logic        exp_rt;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic b, input bit gaps);
      sample_en = 1'b1;
      miso      = b;
      @(negedge clk);
      sample_en = 1'b0;
      miso      = 1'b1;
      if (gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
   endtask

   task automatic send_bits(input logic [39:0] s, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) strobe(s[i], gaps);
   endtask

   task automatic arm(input logic [1:0] t);
      start     = 1'b1;
      resp_type = t;
      @(negedge clk);
      start     = 1'b0;
      chk("busy_rise", 40'(busy0), 40'd1);
   endtask

   task automatic wait_valid0();
      for (int i = 0; i < 20 && vcnt0 == 0; i++) @(negedge clk);
      chk("valid_seen", 40'(vcnt0 > 0), 40'd1);
   endtask

   initial begin
      vecs[0] = '{2'd0,  8, 40'h01,          3,  1'b0, 40'h01,          1'b0};
      vecs[1] = '{2'd3, 40, 40'h00000001AA,  0,  1'b1, 40'h00000001AA,  1'b0};
      vecs[2] = '{2'd2, 16, 40'h00FF,        0,  1'b0, 40'h00FF,        1'b0};
      vecs[3] = '{2'd2, 16, 40'h1234,        2,  1'b1, 40'h1234,        1'b0};
      vecs[4] = '{2'd0,  8, 40'h05,          63, 1'b0, 40'h05,          1'b0};
      vecs[5] = '{2'd0,  0, 40'h0,           64, 1'b0, 40'hFFFFFFFFFF,  1'b1};
      vecs[6] = '{2'd3, 40, 40'h7FFF000081,  5,  1'b0, 40'h7FFF000081,  1'b0};

      reset = 1'b1; sample_en = 1'b0; miso = 1'b1; start = 1'b0;
      abort = 1'b0; resp_type = 2'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy",  40'(busy0), 40'd0);
      chk("rst_valid", 40'(rv0),   40'd0);
      chk("rst_data",  data0,      40'd0);
      chk("rst_rt",    40'(rt0),   40'd0);
      chk("rst_bt",    40'(bt0),   40'd0);

      // Reset after 4 of 16 R2 bits.
      arm(2'd2);
      send_bits(40'h7, 4, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", 40'(busy0), 40'd0);
      chk("midrst_data", data0,      40'd0);
      chk("midrst_flags", 40'({rt0, bt0, rv0}), 40'd0);

      // Abort in the same configuration: no report, data held, no resumption.
      vcnt0 = 0;
      arm(2'd2);
      send_bits(40'h7, 4, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 40'(busy0), 40'd0);
      chk("abort_hold", data0,      40'h7);
      send_bits(40'h0, 20, 1'b0);
      chk("abort_novalid", 40'(vcnt0), 40'd0);

      // Table of complete transactions.
      for (int v = 0; v < 7; v++) begin
         vcnt0 = 0;
         arm(vecs[v].rtype);
         for (int k = 0; k < vecs[v].pre_ones; k++) strobe(1'b1, vecs[v].gaps);
         send_bits(vecs[v].stream, vecs[v].nbits, vecs[v].gaps);
         if (!vecs[v].gaps) chk($sformatf("v%0d_latency", v), 40'(vcnt0), 40'd1);
         wait_valid0();
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_count", v), 40'(vcnt0),  40'd1);
         chk($sformatf("v%0d_data", v),  data0,       vecs[v].exp_data);
         chk($sformatf("v%0d_rt", v),    40'(rt0),    40'(vecs[v].exp_rt));
         chk($sformatf("v%0d_bt", v),    40'(bt0),    40'd0);
         chk($sformatf("v%0d_idle", v),  40'(busy0),  40'd0);
      end

      // R1b: byte 0x00, 100 busy lows then release; dut1 times out at 50 lows.
      vcnt0 = 0; vcnt1 = 0;
      arm(2'd1);
      send_bits(40'h00, 8, 1'b0);
      for (int k = 0; k < 49; k++) strobe(1'b0, 1'b0);
      chk("bt50_early", 40'(vcnt1), 40'd0);
      strobe(1'b0, 1'b0);
      chk("bt50_valid", 40'(vcnt1), 40'd1);
      chk("bt50_flag",  40'(bt1),   40'd1);
      chk("bt50_data",  data1,      40'd0);
      for (int k = 0; k < 50; k++) strobe(1'b0, 1'b0);
      chk("r1b_early", 40'(vcnt0), 40'd0);
      strobe(1'b1, 1'b0);
      chk("r1b_valid", 40'(vcnt0), 40'd1);
      chk("r1b_bt",    40'(bt0),   40'd0);
      chk("r1b_rt",    40'(rt0),   40'd0);
      chk("r1b_data",  data0,      40'd0);
      repeat (3) @(negedge clk);
      chk("r1b_once",  40'(vcnt0), 40'd1);
      chk("bt50_once", 40'(vcnt1), 40'd1);

      // start together with sample_en and MISO=0: that bit is not sampled.
      vcnt0 = 0;
      start = 1'b1; resp_type = 2'd0; sample_en = 1'b1; miso = 1'b0;
      @(negedge clk);
      start = 1'b0; sample_en = 1'b0; miso = 1'b1;
      send_bits(40'h01, 8, 1'b0);
      chk("arm_same_valid", 40'(vcnt0), 40'd1);
      chk("arm_same_data",  data0,      40'h01);
      repeat (3) @(negedge clk);

      // Second start while busy is ignored: type and length stay R1.
      vcnt0 = 0;
      arm(2'd0);
      strobe(1'b0, 1'b0);
      start = 1'b1; resp_type = 2'd2;
      @(negedge clk);
      start = 1'b0;
      send_bits(40'h35, 7, 1'b0);
      chk("restart_valid", 40'(vcnt0), 40'd1);
      chk("restart_data",  data0,      40'h35);
      repeat (3) @(negedge clk);
      chk("restart_once",  40'(vcnt0), 40'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
